// File: rtl/bcd_updown_counter_n_if.sv
// Control and data bundle for the multi-digit BCD up/down counter.
// master drives en/load/up_down/d_in; slave returns count/tc/wrap/load_err.
interface bcd_updown_counter_n_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  load;
    logic                  up_down;
    logic [4*DIGITS-1:0]   d_in;
    logic [4*DIGITS-1:0]   count;
    logic                  tc;
    logic                  wrap;
    logic                  load_err;

    modport master (
        output en, load, up_down, d_in,
        input  count, tc, wrap, load_err
    );

    modport slave (
        input  en, load, up_down, d_in,
        output count, tc, wrap, load_err
    );
endinterface

// File: rtl/bcd_updown_counter_n.sv
// Parametrised DIGITS-decade BCD up/down counter with wrap/saturate mode.
// Ports: clk, rst (sync, active-high), bus (slave: en, load, up_down,
// d_in in; count, tc, wrap, load_err out).
module bcd_updown_counter_n #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_updown_counter_n_if.slave bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] cnt_q;
    logic         wrap_q;
    logic         lerr_q;

    logic [W-1:0] cnt_nxt;
    logic         carry;
    logic         at_end;
    logic         d_ok;
    logic [3:0]   dig;

    // Per-nibble ripple: each decade steps only while the lower decades
    // all sit at their rollover value (9 going up, 0 going down).
    always_comb begin
        cnt_nxt = cnt_q;
        carry   = 1'b1;
        dig     = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = cnt_q[4*i +: 4];
            if (carry) begin
                if (bus.up_down) begin
                    cnt_nxt[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                    carry = (dig == 4'd9);
                end else begin
                    cnt_nxt[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
                    carry = (dig == 4'd0);
                end
            end
        end
        // Carry out of the top decade means the whole value is at the
        // end of range for the current direction.
        at_end = carry;
    end

    always_comb begin
        d_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.d_in[4*i +: 4] > 4'd9) begin
                d_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            lerr_q <= 1'b0;
            if (bus.load) begin
                if (d_ok) begin
                    cnt_q <= bus.d_in;
                end else begin
                    lerr_q <= 1'b1;
                end
            end else if (bus.en) begin
                if (!(at_end && SATURATE)) begin
                    cnt_q  <= cnt_nxt;
                    wrap_q <= at_end;
                end
            end
        end
    end

    assign bus.count    = cnt_q;
    assign bus.tc       = at_end;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = lerr_q;
endmodule
